// File: rtl/dm_store_merge.sv
// Store merge unit: turns sb/sh/sw requests into whole-word writes to a word-only memory.
// Latency: sw writes one cycle after acceptance; sb/sh read, merge and write back over 3 cycles.
// Backpressure: st_ready is high only in IDLE, so a new request stalls until the current store retires.
module dm_store_merge (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        err_align
);

  typedef enum logic [1:0] {IDLE, RD, MERGE, WR} state_t;

  localparam logic [1:0] OP_SB = 2'b01;
  localparam logic [1:0] OP_SH = 2'b10;
  localparam logic [1:0] OP_SW = 2'b11;

  state_t      state;
  logic [1:0]  op_q;
  logic [1:0]  lane_q;     // byte offset within the word
  logic [15:0] half_q;     // only the low half of store data is ever merged
  logic        accept;
  logic        req_ok;
  logic [31:0] merged;

  assign st_ready = (state == IDLE);
  assign accept   = st_valid && st_ready;

  // Alignment check on the incoming request; op 00 is never legal
  always_comb begin
    req_ok = 1'b0;
    case (st_op)
      OP_SB:   req_ok = 1'b1;
      OP_SH:   req_ok = ~st_addr[0];
      OP_SW:   req_ok = (st_addr[1:0] == 2'b00);
      default: req_ok = 1'b0;
    endcase
  end

  // Replace the target lane of the read word; only sb and sh ever reach MERGE
  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_SB) begin
      merged[{lane_q, 3'b000} +: 8] = half_q[7:0];
    end else if (lane_q[1]) begin
      merged[31:16] = half_q;
    end else begin
      merged[15:0] = half_q;
    end
  end

  // Control FSM; memory-side outputs are decoded from the next state and registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      lane_q    <= 2'b00;
      half_q    <= 16'h0000;
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      err_align <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      err_align <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= st_op;
            lane_q <= st_addr[1:0];
            half_q <= st_wdata[15:0];
            if (!req_ok) begin
              err_align <= 1'b1;
            end else if (st_op == OP_SW) begin
              state     <= WR;
              mem_we    <= 1'b1;
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_wdata <= st_wdata;
            end else begin
              state    <= RD;
              mem_rd   <= 1'b1;
              mem_addr <= {st_addr[31:2], 2'b00};
            end
          end
        end
        RD: begin
          state <= MERGE;
        end
        MERGE: begin
          state     <= WR;
          mem_we    <= 1'b1;
          mem_wdata <= merged;
        end
        WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dm_store_merge.md
# dm_store_merge

Store-side companion to the load data extender: accepts sw/sh/sb requests from the MEM stage and turns them into whole-word writes to a word-only data memory. Word stores are written directly. Byte and halfword stores do read-modify-write: read the word, merge the new byte/half, write the word back. Little-endian lane mapping, the same as the load path (lane k = bits [8k+7:8k]).

## Interface
- No parameters. Data and address are fixed at 32 bits.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- st_valid  in  1  store request present.
- st_ready  out  1  block can accept a request; high only in IDLE.
- st_op  in  2  01 = sb, 10 = sh, 11 = sw, 00 = illegal.
- st_addr  in  32  byte address of the store.
- st_wdata  in  32  store data; sb uses [7:0], sh uses [15:0].
- mem_addr  out  32  word address to memory; bits [1:0] are always 00.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  32  read data; valid exactly one cycle after mem_rd.
- mem_we  out  1  one-cycle whole-word write strobe.
- mem_wdata  out  32  word to write; valid while mem_we = 1.
- err_align  out  1  one-cycle pulse for a dropped illegal or misaligned request.

## Operation
- Handshake: a request is accepted on the rising edge where st_valid = 1 and st_ready = 1. On acceptance, op, addr and wdata are captured into internal registers. Inputs are ignored in every other cycle.
- FSM states: IDLE, RD, MERGE, WR.
- Transitions from IDLE on acceptance:
  - sw, aligned: go to WR; write data = st_wdata.
  - sb, or aligned sh: go to RD.
  - Misaligned or illegal request: stay in IDLE; err_align pulses next cycle; no memory access.
- Other transitions: RD -> MERGE -> WR -> IDLE, unconditionally.
- Alignment rules:
  - sw needs addr[1:0] = 00.
  - sh needs addr[0] = 0.
  - sb is always aligned.
  - op 00 is always an error.
- RD: mem_rd = 1, mem_addr = {addr[31:2], 2'b00}.
- MERGE: mem_rdata is sampled into the data register with the target lane replaced:
  - sb: byte addr[1:0] <- wdata[7:0].
  - sh: addr[1] = 0 replaces [15:0]; addr[1] = 1 replaces [31:16]; source is wdata[15:0].
  - All other bits come from mem_rdata unchanged.
- WR: mem_we = 1, mem_addr = word address, mem_wdata = data register.
- Output registering:
  - mem_rd, mem_we, mem_addr and mem_wdata are registered: decoded from the next state and updated on the clock edge. No combinational path from st_* to mem_*.
  - mem_addr and mem_wdata hold their last value while their strobes are low.
- Reset:
  - While reset = 0 (asserted): state = IDLE; mem_rd = mem_we = err_align = 0; mem_addr = mem_wdata = 0; internal registers = 0.
  - st_ready follows IDLE, so it reads 1 once reset is asserted.
- Reset mid-operation: an in-flight store is dropped. No mem_we is issued for it, even if reset lands in MERGE. After release the block is in IDLE.

## Timing
- Cycle N is the acceptance edge.
- sw: mem_we high in cycle N+1; st_ready back high in N+2. Throughput is one sw per 2 cycles.
- sb/sh:
  - mem_rd high in N+1.
  - mem_rdata sampled at the end of N+2 (MERGE).
  - mem_we high in N+3.
  - st_ready high in N+4. Throughput is one per 4 cycles.
- Error case: err_align high in N+1 only; st_ready stays high throughout.
- st_ready is low from N+1 until the cycle the FSM returns to IDLE, so back-to-back requests stall the source.
- At most one of mem_rd and mem_we is high in any cycle.

## Test plan
- Reset release, then no stimulus: mem_we = mem_rd = err_align = 0 and st_ready = 1 every cycle.
- sw: addr 0x0000_1004, data 0xDEAD_BEEF. Expect mem_we in N+1 with mem_addr = 0x1004 and mem_wdata = 0xDEADBEEF; mem_rd never asserts.
- sb: addr 0x1006, data 0x0000_00A5, memory word 0x1122_3344. Expect:
  - mem_rd in N+1 with mem_addr = 0x1004.
  - mem_we in N+3 with mem_wdata = 0x11A5_3344.
- sh, both halves, word 0x1122_3344, data 0xBEEF:
  - addr 0x2002 -> mem_wdata = 0xBEEF_3344.
  - addr 0x2000 -> mem_wdata = 0x1122_BEEF.
- Errors:
  - sw at 0x3002: err_align pulses once; no mem_rd or mem_we.
  - sh at 0x3001: err_align pulses once; no mem_rd or mem_we.
  - st_op = 00: err_align pulses once; no mem_rd or mem_we.
- Reset mid-operation, with a queued second request:
  - Assert reset during the MERGE cycle of an sb. No mem_we follows; after release st_ready = 1.
  - A following sw at 0x10 with data 0x1 writes 0x0000_0001 in N+1.
